// File: rtl/rom_slot_scheduler.sv
// Round-robin scheduler sharing one synchronous sample ROM among
// several audio channels, with latency-matched return routing.
module rom_slot_scheduler #(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                     CLK_50Mhz,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_strobe,
  input  logic [NUM_CH*ADDR_W-1:0] req_index,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_length,
  output logic [ADDR_W-1:0]        rom_address,
  input  logic [DATA_W-1:0]        rom_q,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        data_valid,
  output logic [NUM_CH-1:0]        range_err,
  output logic                     busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW1   = CH_W + 1;
  localparam int DEPTH = ROM_LATENCY + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [NUM_CH-1:0]           pend_q, pend_d, req;
  logic [CH_W-1:0]             ptr_q, ptr_d;
  logic [CH_W-1:0]             gnt_ch, cand;
  logic [CW1-1:0]              sum;
  logic                        gnt_vld;
  logic [ADDR_W-1:0]           sel_idx, sel_base, sel_len;
  logic                        len_zero, clamp, issue;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DEPTH-1:0]            tv_q, tv_d;
  logic [DEPTH-1:0][CH_W-1:0]  tc_q, tc_d;
  logic [CH_W-1:0]             ret_ch;
  logic                        ret;
  logic [NUM_CH*DATA_W-1:0]    dout_q, dout_d;
  logic [NUM_CH-1:0]           dv_q, dv_d;
  logic [NUM_CH-1:0]           rerr_q, rerr_d;
  logic [0:0]                  state_q, state_d;

  // A fresh strobe competes in the same edge it arrives
  always_comb begin
    req     = pend_q | req_strobe;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    sum     = '0;
    cand    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      sum = {1'b0, ptr_q} + CW1'(n);
      if (sum >= CW1'(NUM_CH)) sum = sum - CW1'(NUM_CH);
      cand = sum[CH_W-1:0];
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  always_comb begin
    sel_idx  = req_index[gnt_ch*ADDR_W +: ADDR_W];
    sel_base = ch_base[gnt_ch*ADDR_W +: ADDR_W];
    sel_len  = ch_length[gnt_ch*ADDR_W +: ADDR_W];
    len_zero = (sel_len == '0);
    clamp    = (sel_idx >= sel_len);
    issue    = gnt_vld && !len_zero;
    addr_d   = addr_q;
    if (issue)
      addr_d = clamp ? sel_base + sel_len - ADDR_W'(1)
                     : sel_base + sel_idx;
  end

  always_comb begin
    pend_d = req;
    ptr_d  = ptr_q;
    rerr_d = '0;
    if (gnt_vld) begin
      pend_d[gnt_ch] = pend_q[gnt_ch] & req_strobe[gnt_ch];
      ptr_d = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
      rerr_d[gnt_ch] = len_zero | clamp;
    end
  end

  // Tag pipeline tracks which channel owns each word in the ROM
  always_comb begin
    tv_d   = {tv_q[DEPTH-2:0], issue};
    tc_d   = {tc_q[DEPTH-2:0], gnt_ch};
    ret    = tv_q[DEPTH-1];
    ret_ch = tc_q[DEPTH-1];
    dv_d   = '0;
    dout_d = dout_q;
    if (ret) begin
      dv_d[ret_ch] = 1'b1;
      dout_d[ret_ch*DATA_W +: DATA_W] = rom_q;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    unique case (1'b1)
      (|pend_d), (|tv_d), (|dv_d): state_d = S_RUN;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50Mhz or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      tv_q    <= '0;
      tc_q    <= '0;
      dout_q  <= '0;
      dv_q    <= '0;
      rerr_q  <= '0;
      state_q <= S_IDLE;
    end else begin
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      tv_q    <= tv_d;
      tc_q    <= tc_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      rerr_q  <= rerr_d;
      state_q <= state_d;
    end
  end

  assign rom_address = addr_q;
  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign range_err   = rerr_q;
  assign busy        = (state_q == S_RUN);

endmodule

// File: tb/tb_rom_slot_scheduler.sv
// Bench for rom_slot_scheduler: ROM latency 1 and 2 instances side by side,
// checked against directed tables and a time-wheel reference model.
module tb_rom_slot_scheduler;

  logic        clk, rst;
  logic [2:0]  stb;
  logic [47:0] idx, base, len;
  logic [15:0] addr1, addr2, q1, q2, a2;
  logic [47:0] dout1, dout2;
  logic [2:0]  dv1, dv2, rerr1, rerr2;
  logic        busy1, busy2;

  rom_slot_scheduler #(.NUM_CH(3), .ADDR_W(16), .DATA_W(16), .ROM_LATENCY(1)) u1 (
    .CLK_50Mhz(clk), .reset(rst), .req_strobe(stb), .req_index(idx),
    .ch_base(base), .ch_length(len), .rom_address(addr1), .rom_q(q1),
    .data_out(dout1), .data_valid(dv1), .range_err(rerr1), .busy(busy1));

  rom_slot_scheduler #(.NUM_CH(3), .ADDR_W(16), .DATA_W(16), .ROM_LATENCY(2)) u2 (
    .CLK_50Mhz(clk), .reset(rst), .req_strobe(stb), .req_index(idx),
    .ch_base(base), .ch_length(len), .rom_address(addr2), .rom_q(q2),
    .data_out(dout2), .data_valid(dv2), .range_err(rerr2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word = address
  always @(posedge clk) begin
    q1 <= addr1;
    a2 <= addr2;
    q2 <= a2;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending set, pointer, and a time wheel of returns
  logic [2:0]  m_pend [2];
  int          m_ptr  [2];
  logic [15:0] m_addr [2];
  logic [47:0] m_dout [2];
  logic [2:0]  m_dv   [2];
  logic [2:0]  m_rerr [2];
  logic        m_busy [2];
  logic        w_v    [2][8];
  int          w_ch   [2][8];
  logic [15:0] w_d    [2][8];
  int          cyc = 0;

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_pend[j] = '0; m_ptr[j] = 0; m_addr[j] = '0; m_dout[j] = '0;
      m_dv[j] = '0; m_rerr[j] = '0; m_busy[j] = 1'b0;
      for (int t = 0; t < 8; t++) w_v[j][t] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int s, got, c, ch;
    logic [15:0] b, ln, x, a;
    for (int j = 0; j < 2; j++) begin
      s = cyc % 8;
      m_dv[j] = '0;
      m_rerr[j] = '0;
      if (w_v[j][s]) begin
        ch = w_ch[j][s];
        m_dv[j][ch] = 1'b1;
        m_dout[j][ch*16 +: 16] = w_d[j][s];
        w_v[j][s] = 1'b0;
      end
      got = -1;
      for (int n = 0; n < 3; n++) begin
        c = (m_ptr[j] + n) % 3;
        if (got < 0 && (m_pend[j][c] || stb[c])) got = c;
      end
      for (int k = 0; k < 3; k++)
        m_pend[j][k] = (k == got) ? (m_pend[j][k] & stb[k])
                                  : (m_pend[j][k] | stb[k]);
      if (got >= 0) begin
        m_ptr[j] = (got + 1) % 3;
        b  = base[got*16 +: 16];
        ln = len[got*16 +: 16];
        x  = idx[got*16 +: 16];
        if (ln == 16'd0) begin
          m_rerr[j][got] = 1'b1;
        end else begin
          if (x >= ln) begin
            a = b + ln - 16'd1;
            m_rerr[j][got] = 1'b1;
          end else begin
            a = b + x;
          end
          m_addr[j] = a;
          w_v[j][(cyc + j + 2) % 8]  = 1'b1;
          w_ch[j][(cyc + j + 2) % 8] = got;
          w_d[j][(cyc + j + 2) % 8]  = a;
        end
      end
      m_busy[j] = (m_pend[j] != 3'b0) || (m_dv[j] != 3'b0);
      for (int t = 0; t < 8; t++) if (w_v[j][t]) m_busy[j] = 1'b1;
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("addr1", 48'(addr1), 48'(m_addr[0]));
    chk("dout1", dout1, m_dout[0]);
    chk("dv1",   48'(dv1), 48'(m_dv[0]));
    chk("rerr1", 48'(rerr1), 48'(m_rerr[0]));
    chk("busy1", 48'(busy1), 48'(m_busy[0]));
    chk("addr2", 48'(addr2), 48'(m_addr[1]));
    chk("dout2", dout2, m_dout[1]);
    chk("dv2",   48'(dv2), 48'(m_dv[1]));
    chk("rerr2", 48'(rerr2), 48'(m_rerr[1]));
    chk("busy2", 48'(busy2), 48'(m_busy[1]));
  endtask

  task automatic step();
    if (!rst) model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stb = '0;
    model_reset();
    #1;
    compare_all();
    chk("rst_dout1", dout1, 48'd0);
    chk("rst_dv2", 48'(dv2), 48'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  stb;
    logic [15:0] i0, i1, i2;
    logic [15:0] addr;
    logic [47:0] dout;
    logic [2:0]  dv, rerr;
    logic        busy;
    logic [2:0]  dv2;
  } vec_t;

  vec_t tbl [14];
  int   cnt [3];

  initial begin
    rst  = 1'b1;
    stb  = '0;
    idx  = '0;
    base = {16'd9000, 16'd4000, 16'd0};
    len  = {16'd2000, 16'd5000, 16'd4000};
    model_reset();

    tbl[0]  = '{3'b000, 16'd0, 16'd0,  16'd0,    16'd0,     {16'd0,     16'd0,    16'd0}, 3'b000, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{3'b010, 16'd0, 16'd10, 16'd0,    16'd4010,  {16'd0,     16'd0,    16'd0}, 3'b000, 3'b000, 1'b1, 3'b000};
    tbl[2]  = '{3'b000, 16'd0, 16'd10, 16'd0,    16'd4010,  {16'd0,     16'd0,    16'd0}, 3'b000, 3'b000, 1'b1, 3'b000};
    tbl[3]  = '{3'b000, 16'd0, 16'd10, 16'd0,    16'd4010,  {16'd0,     16'd4010, 16'd0}, 3'b010, 3'b000, 1'b1, 3'b000};
    tbl[4]  = '{3'b100, 16'd0, 16'd0,  16'd2500, 16'd10999, {16'd0,     16'd4010, 16'd0}, 3'b000, 3'b100, 1'b1, 3'b010};
    tbl[5]  = '{3'b000, 16'd0, 16'd0,  16'd2500, 16'd10999, {16'd0,     16'd4010, 16'd0}, 3'b000, 3'b000, 1'b1, 3'b000};
    tbl[6]  = '{3'b000, 16'd0, 16'd0,  16'd2500, 16'd10999, {16'd10999, 16'd4010, 16'd0}, 3'b100, 3'b000, 1'b1, 3'b000};
    tbl[7]  = '{3'b111, 16'd1, 16'd2,  16'd3,    16'd1,     {16'd10999, 16'd4010, 16'd0}, 3'b000, 3'b000, 1'b1, 3'b100};
    tbl[8]  = '{3'b000, 16'd1, 16'd2,  16'd3,    16'd4002,  {16'd10999, 16'd4010, 16'd0}, 3'b000, 3'b000, 1'b1, 3'b000};
    tbl[9]  = '{3'b000, 16'd1, 16'd2,  16'd3,    16'd9003,  {16'd10999, 16'd4010, 16'd1}, 3'b001, 3'b000, 1'b1, 3'b000};
    tbl[10] = '{3'b000, 16'd1, 16'd2,  16'd3,    16'd9003,  {16'd10999, 16'd4002, 16'd1}, 3'b010, 3'b000, 1'b1, 3'b001};
    tbl[11] = '{3'b000, 16'd1, 16'd2,  16'd3,    16'd9003,  {16'd9003,  16'd4002, 16'd1}, 3'b100, 3'b000, 1'b1, 3'b010};
    tbl[12] = '{3'b000, 16'd1, 16'd2,  16'd3,    16'd9003,  {16'd9003,  16'd4002, 16'd1}, 3'b000, 3'b000, 1'b0, 3'b100};
    tbl[13] = '{3'b000, 16'd1, 16'd2,  16'd3,    16'd9003,  {16'd9003,  16'd4002, 16'd1}, 3'b000, 3'b000, 1'b0, 3'b000};

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_addr", 48'(addr1), 48'd0);
    end

    for (int i = 0; i < 14; i++) begin
      stb = tbl[i].stb;
      idx = {tbl[i].i2, tbl[i].i1, tbl[i].i0};
      step();
      chk("tbl_addr", 48'(addr1), 48'(tbl[i].addr));
      chk("tbl_dout", dout1, tbl[i].dout);
      chk("tbl_dv",   48'(dv1), 48'(tbl[i].dv));
      chk("tbl_rerr", 48'(rerr1), 48'(tbl[i].rerr));
      chk("tbl_busy", 48'(busy1), 48'(tbl[i].busy));
      chk("tbl_dv2",  48'(dv2), 48'(tbl[i].dv2));
    end

    // Zero-length channel: error pulse only, no read
    len[15:0] = 16'd0;
    stb = 3'b001;
    idx = '0;
    step();
    chk("zl_rerr", 48'(rerr1), 48'd1);
    chk("zl_addr", 48'(addr1), 48'd9003);
    cnt[0] = 0;
    stb = 3'b000;
    for (int i = 0; i < 5; i++) begin
      step();
      if (dv1[0] || dv2[0]) cnt[0]++;
      chk("zl_rerr_once", 48'(rerr1), 48'd0);
    end
    chk("zl_no_valid", 48'(cnt[0]), 48'd0);
    len[15:0] = 16'd4000;

    // Strobe coinciding with its own grant adds one grant (ptr is 1 here)
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int i = 0; i < 10; i++) begin
      stb = (i == 0) ? 3'b110 : (i == 1) ? 3'b100 : 3'b000;
      step();
      for (int c = 0; c < 3; c++) if (dv1[c]) cnt[c]++;
    end
    chk("coin_ch0", 48'(cnt[0]), 48'd0);
    chk("coin_ch1", 48'(cnt[1]), 48'd1);
    chk("coin_ch2", 48'(cnt[2]), 48'd2);

    // Strobe while already pending is absorbed (ptr is 0 here)
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int i = 0; i < 10; i++) begin
      stb = (i == 0) ? 3'b111 : (i == 1) ? 3'b100 : 3'b000;
      step();
      for (int c = 0; c < 3; c++) if (dv1[c]) cnt[c]++;
    end
    chk("abs_ch0", 48'(cnt[0]), 48'd1);
    chk("abs_ch1", 48'(cnt[1]), 48'd1);
    chk("abs_ch2", 48'(cnt[2]), 48'd1);

    // 30 cycles of continuous strobes: 30 grants plus 3 to drain
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int i = 0; i < 40; i++) begin
      stb = (i < 30) ? 3'b111 : 3'b000;
      idx = {16'($urandom_range(0, 3000)), 16'($urandom_range(0, 6000)),
             16'($urandom_range(0, 5000))};
      step();
      for (int c = 0; c < 3; c++) if (dv1[c]) cnt[c]++;
    end
    chk("cont_ch0", 48'(cnt[0]), 48'd11);
    chk("cont_ch1", 48'(cnt[1]), 48'd11);
    chk("cont_ch2", 48'(cnt[2]), 48'd11);

    // Reset with reads in flight
    stb = 3'b011;
    idx = {16'd7, 16'd8, 16'd9};
    step();
    stb = 3'b000;
    step();
    do_reset();
    cnt[0] = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (dv1 != 3'b0 || dv2 != 3'b0) cnt[0]++;
    end
    chk("rst_no_valid", 48'(cnt[0]), 48'd0);
    chk("rst_dout_hold", dout2, 48'd0);
    stb = 3'b111;
    idx = {16'd3, 16'd4, 16'd5};
    step();
    chk("rst_ptr", 48'(addr1), 48'd5);
    stb = 3'b000;
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic against the model
    for (int c = 0; c < 3; c++) begin
      base[c*16 +: 16] = 16'($urandom);
      len[c*16 +: 16]  = ($urandom_range(0, 5) == 0) ? 16'd0
                                                      : 16'($urandom_range(1, 8000));
    end
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        stb = 3'($urandom) & 3'($urandom | $urandom);
        idx = {16'($urandom_range(0, 9000)), 16'($urandom_range(0, 9000)),
               16'($urandom_range(0, 9000))};
        step();
      end
    end
    stb = 3'b000;
    for (int i = 0; i < 8; i++) step();
    chk("final_idle1", 48'(busy1), 48'd0);
    chk("final_idle2", 48'(busy2), 48'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
